// File: rtl/pmem_arbiter.sv
// pmem_arbiter: shares one physical-memory line port between the I-cache and
// the D-cache. One requester is granted at a time; its request is registered
// onto the memory port and held until pmem_resp, then the arbiter spends one
// IDLE cycle before the next grant. Ties are broken round-robin.
//
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   i_pmem_* / d_pmem_*           cache-side request (read/write/address/wdata)
//                                 and response (resp/rdata) interfaces
//   pmem_read/write/address/wdata registered request to memory
//   pmem_resp/pmem_rdata          memory completion pulse and read line
module pmem_arbiter #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_pmem_read,
    input  logic              i_pmem_write,
    input  logic [ADDR_W-1:0] i_pmem_address,
    input  logic [LINE_W-1:0] i_pmem_wdata,
    output logic              i_pmem_resp,
    output logic [LINE_W-1:0] i_pmem_rdata,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic              d_pmem_resp,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic              pmem_resp,
    input  logic [LINE_W-1:0] pmem_rdata
);

    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;

    typedef struct packed {
        logic              rd;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] wdata;
    } req_t;

    state_t state, state_nx;
    logic   last_d;          // 1: D was granted last, 0: I (reset value)
    logic   req_i, req_d;
    logic   win_i, win_d;
    req_t   win_req;

    assign req_i = i_pmem_read | i_pmem_write;
    assign req_d = d_pmem_read | d_pmem_write;

    // On a tie the requester that did not win last time gets the port.
    assign win_d = req_d & (~req_i | ~last_d);
    assign win_i = req_i & ~win_d;

    // Read+write together is illegal; it is issued as a write.
    always_comb begin
        win_req = '0;
        if (win_d) begin
            win_req.rd    = d_pmem_read & ~d_pmem_write;
            win_req.wr    = d_pmem_write;
            win_req.addr  = d_pmem_address;
            win_req.wdata = d_pmem_wdata;
        end else begin
            win_req.rd    = i_pmem_read & ~i_pmem_write;
            win_req.wr    = i_pmem_write;
            win_req.addr  = i_pmem_address;
            win_req.wdata = i_pmem_wdata;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (win_d)      state_nx = GRANT_D;
                else if (win_i) state_nx = GRANT_I;
            end
            GRANT_I, GRANT_D: begin
                // Always return through IDLE so a cache's strobe that is
                // still high in its resp cycle cannot be granted again.
                if (pmem_resp) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_d       <= 1'b0;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
        end else if (state == IDLE) begin
            if (win_i | win_d) begin
                last_d       <= win_d;
                pmem_read    <= win_req.rd;
                pmem_write   <= win_req.wr;
                pmem_address <= win_req.addr;
                pmem_wdata   <= win_req.wdata;
            end
        end else if (pmem_resp) begin
            // Address/wdata deliberately keep their last value.
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
        end
    end

    assign i_pmem_resp  = pmem_resp & (state == GRANT_I);
    assign d_pmem_resp  = pmem_resp & (state == GRANT_D);
    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter: inputs change on the falling edge, outputs
// are checked 1 time unit later, with expected values worked out by hand.
module tb_pmem_arbiter;
    localparam int LW = 256;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_read, i_write, d_read, d_write;
    logic [AW-1:0] i_addr, d_addr;
    logic [LW-1:0] i_wdata, d_wdata;
    logic          i_resp, d_resp;
    logic [LW-1:0] i_rdata, d_rdata;
    logic          m_read, m_write;
    logic [AW-1:0] m_addr;
    logic [LW-1:0] m_wdata;
    logic          m_resp;
    logic [LW-1:0] m_rdata;

    int n_vec  = 0;
    int n_miss = 0;

    logic [LW-1:0] pat_a5, pat_5a, line1;

    always #5 clk = ~clk;

    pmem_arbiter #(.LINE_W(LW), .ADDR_W(AW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_pmem_read   (i_read),
        .i_pmem_write  (i_write),
        .i_pmem_address(i_addr),
        .i_pmem_wdata  (i_wdata),
        .i_pmem_resp   (i_resp),
        .i_pmem_rdata  (i_rdata),
        .d_pmem_read   (d_read),
        .d_pmem_write  (d_write),
        .d_pmem_address(d_addr),
        .d_pmem_wdata  (d_wdata),
        .d_pmem_resp   (d_resp),
        .d_pmem_rdata  (d_rdata),
        .pmem_read     (m_read),
        .pmem_write    (m_write),
        .pmem_address  (m_addr),
        .pmem_wdata    (m_wdata),
        .pmem_resp     (m_resp),
        .pmem_rdata    (m_rdata)
    );

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {read, write, i_resp, d_resp} all low
    task automatic chk_quiet(input string tag);
        chk(tag, {m_read, m_write, i_resp, d_resp}, 4'b0000);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        pat_a5 = {32{8'hA5}};
        pat_5a = {32{8'h5A}};
        line1  = {8{32'hCAFE_0000 + 32'h1}};
        rst_n = 1'b0;
        {i_read, i_write, d_read, d_write, m_resp} = '0;
        i_addr = '0; d_addr = '0; i_wdata = '0; d_wdata = '0; m_rdata = '0;

        // ---- reset state
        #1;
        chk("rst_strobes", {m_read, m_write, i_resp, d_resp}, 4'b0000);
        chk("rst_addr", m_addr, '0);
        chk("rst_wdata", m_wdata, '0);
        step(); rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step(); #1 chk_quiet("idle_after_rst");
        end

        // ---- I-cache read 0x1040, memory responds 5 cycles after strobe
        step(); i_read = 1'b1; i_addr = 32'h0000_1040;
        #1 chk("ird_not_yet", m_read, 1'b0);
        step(); #1 chk("ird_strobe", {m_read, m_write}, 2'b10);
        chk("ird_addr", m_addr, 32'h0000_1040);
        for (int k = 0; k < 4; k++) begin
            step(); #1 chk("ird_hold", {m_read, i_resp, d_resp}, 3'b100);
        end
        step(); m_resp = 1'b1; m_rdata = line1;
        #1 chk("ird_resp", {i_resp, d_resp}, 2'b10);
        chk("ird_irdata", i_rdata, line1);
        chk("ird_drdata", d_rdata, line1);
        step(); m_resp = 1'b0; i_read = 1'b0;
        #1 chk_quiet("ird_done");
        step(); #1 chk_quiet("ird_no_regrant");

        // ---- pmem_resp while IDLE is ignored
        step(); m_resp = 1'b1;
        #1 chk("idle_resp", {i_resp, d_resp}, 2'b00);
        step(); m_resp = 1'b0;
        #1 chk_quiet("idle_resp_after");

        // ---- tie after reset: D wins, then I
        step(); rst_n = 1'b0; #1 rst_n = 1'b1;
        step();
        i_read = 1'b1; i_addr = 32'h100;
        d_write = 1'b1; d_addr = 32'h200; d_wdata = pat_a5;
        step(); #1 chk("tie1_d_first", {m_read, m_write}, 2'b01);
        chk("tie1_d_addr", m_addr, 32'h200);
        chk("tie1_d_wdata", m_wdata, pat_a5);
        step(); m_resp = 1'b1;
        #1 chk("tie1_d_resp", {i_resp, d_resp}, 2'b01);
        step(); m_resp = 1'b0; d_write = 1'b0;
        #1 chk_quiet("tie1_turnaround");
        step(); #1 chk("tie1_i_next", {m_read, m_write}, 2'b10);
        chk("tie1_i_addr", m_addr, 32'h100);
        step(); m_resp = 1'b1;
        #1 chk("tie1_i_resp", {i_resp, d_resp}, 2'b10);
        step(); m_resp = 1'b0; i_read = 1'b0;
        #1 chk_quiet("tie1_done");

        // ---- D-only read so D is last granted; next tie goes to I
        step(); d_read = 1'b1; d_addr = 32'h240;
        step(); #1 chk("dread_addr", {m_read, m_write, m_addr}, {2'b10, 32'h240});
        step(); m_resp = 1'b1;
        #1 chk("dread_resp", {i_resp, d_resp}, 2'b01);
        step(); m_resp = 1'b0; d_read = 1'b0;
        #1 chk_quiet("dread_done");

        step();
        i_read = 1'b1; i_addr = 32'h100;
        d_write = 1'b1; d_addr = 32'h200; d_wdata = pat_a5;
        step(); #1 chk("tie2_i_first", {m_read, m_write, m_addr}, {2'b10, 32'h100});
        step(); m_resp = 1'b1;
        #1 chk("tie2_i_resp", {i_resp, d_resp}, 2'b10);
        step(); m_resp = 1'b0; i_read = 1'b0;
        #1 chk_quiet("tie2_turnaround");
        step(); #1 chk("tie2_d_next", {m_read, m_write, m_addr}, {2'b01, 32'h200});
        step(); m_resp = 1'b1;
        #1 chk("tie2_d_resp", {i_resp, d_resp}, 2'b01);
        step(); m_resp = 1'b0; d_write = 1'b0;
        #1 chk_quiet("tie2_done");

        // ---- D dirty miss: writeback 0x300 then read 0x340
        step(); d_write = 1'b1; d_addr = 32'h300; d_wdata = pat_5a;
        step(); #1 chk("dm_wb", {m_read, m_write, m_addr}, {2'b01, 32'h300});
        chk("dm_wb_wdata", m_wdata, pat_5a);
        step(); m_resp = 1'b1;
        #1 chk("dm_wb_resp", d_resp, 1'b1);
        step(); m_resp = 1'b0; d_write = 1'b0; d_read = 1'b1; d_addr = 32'h340;
        #1 chk("dm_turnaround", {m_read, m_write}, 2'b00);
        step(); #1 chk("dm_read", {m_read, m_write, m_addr}, {2'b10, 32'h340});
        step(); m_resp = 1'b1;
        #1 chk("dm_read_resp", {i_resp, d_resp}, 2'b01);
        step(); m_resp = 1'b0; d_read = 1'b0;
        #1 chk_quiet("dm_done");

        // ---- address change mid-grant is ignored
        step(); d_read = 1'b1; d_addr = 32'h400;
        step(); #1 chk("mid_addr0", {m_read, m_addr}, {1'b1, 32'h400});
        d_addr = 32'h480;
        step(); #1 chk("mid_addr1", m_addr, 32'h400);
        step(); m_resp = 1'b1;
        #1 chk("mid_addr_resp", {d_resp, m_addr}, {1'b1, 32'h400});
        step(); m_resp = 1'b0; d_read = 1'b0;
        #1 chk("mid_addr_kept", {m_read, m_addr}, {1'b0, 32'h400});

        // ---- async reset during GRANT_I
        step(); i_read = 1'b1; i_addr = 32'h500;
        step(); #1 chk("arst_pre", {m_read, m_addr}, {1'b1, 32'h500});
        #2 rst_n = 1'b0;
        #1 chk("arst_read", m_read, 1'b0);
        chk("arst_addr", m_addr, '0);
        i_read = 1'b0;
        step(); rst_n = 1'b1;
        step(); #1 chk_quiet("arst_idle");

        step();
        i_read = 1'b1; i_addr = 32'h100;
        d_write = 1'b1; d_addr = 32'h200; d_wdata = pat_a5;
        step(); #1 chk("arst_tie_d", {m_read, m_write, m_addr}, {2'b01, 32'h200});
        step(); m_resp = 1'b1;
        #1 chk("arst_tie_resp", {i_resp, d_resp}, 2'b01);
        step(); m_resp = 1'b0; d_write = 1'b0; i_read = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
